// File: rtl/payload_fifo_sync_ctrl.sv
// Single-clock payload FIFO with an inferred dual-port RAM, optional output pipeline
// and standard or first-word-fall-through read mode.
module payload_fifo_sync_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 128,
    parameter int PIPE      = 1,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             WEN,
    input  logic             REN,
    output logic [WIDTH-1:0] RDATA,
    output logic             RVALID,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output logic [CW-1:0]    COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    // Read path is a chain of stages: RAM read register, optional pipe register,
    // and (FWFT only) a presentation register that holds the head word until popped.
    localparam int NS = 1 + PIPE + FWFT;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    ram_cnt;
    logic [WIDTH-1:0] stg_q [NS];
    logic [NS-1:0]    stg_vld;
    logic [NS-1:0]    stg_rdy;
    logic             wr_acc;
    logic             pop;
    logic             fetch;
    logic             out_rdy;

    assign FULL         = (count == DEPTH_C);
    assign EMPTY        = (FWFT != 0) ? !stg_vld[NS-1] : (count == '0);
    assign ALMOST_FULL  = (count >= AFULL_C);
    assign ALMOST_EMPTY = (count <= AEMPTY_C);
    assign COUNT        = count;
    assign RDATA        = stg_q[NS-1];
    assign RVALID       = stg_vld[NS-1];

    assign wr_acc  = WEN && !FULL;
    assign pop     = REN && !EMPTY;
    assign out_rdy = (FWFT != 0) ? REN : 1'b1;
    // ram_cnt counts words still in RAM; in standard mode every accepted read fetches.
    assign fetch   = (FWFT != 0) ? ((ram_cnt != '0) && stg_rdy[0]) : pop;

    // A stage may load when the output is being drained or some stage at or after it is empty.
    always_comb begin : rdy_chain
        logic all_full;
        stg_rdy  = '0;
        all_full = 1'b1;
        for (int k = 0; k < NS; k++) begin
            all_full = 1'b1;
            for (int j = k; j < NS; j++) begin
                all_full = all_full & stg_vld[j];
            end
            stg_rdy[k] = out_rdy | ~all_full;
        end
    end

    // NOTE: the storage array has no reset so it can map onto block RAM; only the
    // pointers and valid bits around it need a defined state after reset.
    always_ff @(posedge CLOCK) begin
        if (RESET_N && wr_acc) begin
            mem[wptr] <= WDATA;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values, e.g. FULL for the overflow decision even when a pop coincides.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ram_cnt   <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
            stg_vld   <= '0;
            for (int k = 0; k < NS; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            if (wr_acc) begin
                wptr <= (wptr == LAST_ADDR) ? '0 : wptr + AW'(1);
            end
            if (fetch) begin
                rptr <= (rptr == LAST_ADDR) ? '0 : rptr + AW'(1);
            end

            if (wr_acc && !pop) begin
                count <= count + CW'(1);
            end else if (!wr_acc && pop) begin
                count <= count - CW'(1);
            end

            if (wr_acc && !fetch) begin
                ram_cnt <= ram_cnt + CW'(1);
            end else if (!wr_acc && fetch) begin
                ram_cnt <= ram_cnt - CW'(1);
            end

            if (WEN && FULL) begin
                OVERFLOW <= 1'b1;
            end
            if (REN && EMPTY) begin
                UNDERFLOW <= 1'b1;
            end

            if (stg_rdy[0]) begin
                stg_vld[0] <= fetch;
                if (fetch) begin
                    stg_q[0] <= mem[rptr];
                end
            end
            // Data only moves with a valid word, so RDATA holds its last value otherwise.
            for (int k = 1; k < NS; k++) begin
                if (stg_rdy[k]) begin
                    stg_vld[k] <= stg_vld[k-1];
                    if (stg_vld[k-1]) begin
                        stg_q[k] <= stg_q[k-1];
                    end
                end
            end
        end
    end

endmodule
